// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// One byte per grant; waits for the tx_done rising edge (or a watchdog abort) before re-arbitrating.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 131072,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_sent,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_din,
  input  logic                          tx_done,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_id;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              transfer;
  logic              tx_done_q;
  logic              done_rise;
  logic              wd_expire;
  logic [CNT_W-1:0]  wd_cnt;

  // Index last+k modulo NUM_REQ; k never exceeds NUM_REQ so one subtraction suffices.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the search so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[rr_index(last_id, k)]) begin
        found  = 1'b1;
        winner = rr_index(last_id, k);
      end
    end
  end

  assign transfer  = (state == IDLE) && found;
  assign done_rise = tx_done & ~tx_done_q;
  assign wd_expire = WD_EN && (wd_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    tx_start  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) begin
          req_ready[winner] = 1'b1;
          state_nxt         = START;
        end
      end
      START: begin
        tx_start  = 1'b1;
        busy      = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (done_rise || wd_expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_id     <= ID_W'(NUM_REQ - 1);
      grant_id    <= '0;
      tx_din      <= '0;
      tx_done_q   <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      req_sent    <= '0;
    end else begin
      state     <= state_nxt;
      tx_done_q <= tx_done;
      req_sent  <= '0;
      if (transfer) begin
        tx_din   <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
        grant_id <= winner;
        last_id  <= winner;
      end
      if (state == START)     wd_cnt <= '0;
      else if (state == BUSY) wd_cnt <= wd_cnt + 1'b1;
      // Completion wins over a watchdog expiry landing in the same cycle.
      if (state == BUSY) begin
        if (done_rise)      req_sent[grant_id] <= 1'b1;
        else if (wd_expire) timeout_err        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected frames, a monitor pops and compares.
// A small transmitter model drives tx_done with configurable stale/stuck/frame-length behaviour.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ*DW-1:0] req_data = '0;
  logic [NUM_REQ-1:0] req_ready, req_sent;
  logic              tx_start;
  logic [DW-1:0]     tx_din;
  logic              tx_done = 1'b1;
  logic [1:0]        grant_id;
  logic              busy, timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_sent(req_sent), .tx_start(tx_start), .tx_din(tx_din),
    .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] din;
    logic [1:0]    id;
  } start_exp_t;

  start_exp_t         start_q[$];
  logic [NUM_REQ-1:0] sent_q[$];

  task automatic push_frame(input logic [1:0] id, input logic [DW-1:0] din, input bit sent);
    start_q.push_back('{din: din, id: id});
    if (sent) sent_q.push_back(NUM_REQ'(1) << id);
  endtask

  // Transmitter model
  int frame_delay  = 19;
  int stale_cycles = 0;
  bit stuck        = 1'b0;
  bit kill         = 1'b0;
  int done_rise_cyc = 0;
  bit gap_armed    = 1'b0;
  bit gap_check    = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && !reset) begin
        for (int i = 0; i < stale_cycles && !kill; i++) @(negedge clk);
        tx_done = 1'b0;
        if (!stuck) begin
          for (int i = 0; i < frame_delay && !kill; i++) @(negedge clk);
          tx_done = 1'b1;
          if (!kill) begin
            done_rise_cyc = cyc;
            gap_armed     = 1'b1;
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  logic [DW-1:0] held_din = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        if (start_q.size() == 0) begin
          check("start_unexpected", 32'(tx_start), 32'd0);
        end else begin
          start_exp_t e;
          e = start_q.pop_front();
          check("start_din", 32'(tx_din), 32'(e.din));
          check("start_grant_id", 32'(grant_id), 32'(e.id));
        end
        held_din = tx_din;
        if (gap_check && gap_armed) begin
          check("done_to_start_gap", 32'(cyc - done_rise_cyc), 32'd2);
          gap_armed = 1'b0;
        end
      end else if (busy) begin
        check("din_stable", 32'(tx_din), 32'(held_din));
      end
      if (req_sent != '0) begin
        if (sent_q.size() == 0) check("sent_unexpected", 32'(req_sent), 32'd0);
        else check("req_sent", 32'(req_sent), 32'(sent_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    kill      = 1'b1;
    reset     = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    tx_done      = 1'b1;
    stuck        = 1'b0;
    stale_cycles = 0;
    gap_armed    = 1'b0;
    kill         = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic wait_start(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_start) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_sent(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_sent != '0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("sent_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (start_q.size() == 0 && sent_q.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", 32'(start_q.size() + sent_q.size()), 32'd0);
  endtask

  int t, s, c;

  initial begin
    do_reset();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_din", 32'(tx_din), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_req_sent", 32'(req_sent), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);

    // Single request: latency and completion timing
    frame_delay = 19;
    push_frame(2'd0, 8'hA5, 1'b1);
    req_data  = {8'h00, 8'h00, 8'h00, 8'hA5};
    req_valid = 4'b0001;
    t = cyc;
    #1 check("single_req_ready", 32'(req_ready), 32'b0001);
    wait_start(s);
    check("single_start_latency", 32'(s - t), 32'd1);
    req_valid = '0;
    @(negedge clk);
    check("single_start_one_cycle", 32'(tx_start), 32'd0);
    wait_sent(c);
    check("single_sent_latency", 32'(c - t), 32'd21);
    check("single_busy_after", 32'(busy), 32'd0);
    drain();

    // Contention 1010 from reset: 1,3,1,3
    do_reset();
    frame_delay = 5;
    req_data = {8'hD3, 8'h00, 8'hB1, 8'h00};
    push_frame(2'd1, 8'hB1, 1'b1);
    push_frame(2'd3, 8'hD3, 1'b1);
    push_frame(2'd1, 8'hB1, 1'b1);
    push_frame(2'd3, 8'hD3, 1'b1);
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) wait_start(s);
    req_valid = '0;
    drain();

    // Full fairness with done-to-start gap check
    do_reset();
    frame_delay = 6;
    gap_check   = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    push_frame(2'd0, 8'h11, 1'b1);
    push_frame(2'd1, 8'h22, 1'b1);
    push_frame(2'd2, 8'h33, 1'b1);
    push_frame(2'd3, 8'h44, 1'b1);
    push_frame(2'd0, 8'h11, 1'b1);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) wait_start(s);
    req_valid = '0;
    drain();
    gap_check = 1'b0;

    // Stale done: high on entry to BUSY, completion only on the later rise
    do_reset();
    stale_cycles = 5;
    frame_delay  = 10;
    req_data = {8'h00, 8'h00, 8'h9E, 8'h00};
    push_frame(2'd1, 8'h9E, 1'b1);
    req_valid = 4'b0010;
    wait_start(s);
    req_valid = '0;
    while (cyc < s + 10) @(negedge clk);
    check("stale_busy", 32'(busy), 32'd1);
    check("stale_no_sent", 32'(req_sent), 32'd0);
    wait_sent(c);
    check("stale_sent_after_rise", 32'(c - done_rise_cyc), 32'd1);
    check("stale_sent_cycle", 32'(c - s), 32'd16);
    drain();

    // Watchdog: tx_done stuck low
    do_reset();
    stuck    = 1'b1;
    req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
    push_frame(2'd0, 8'h3C, 1'b0);
    req_valid = 4'b0001;
    wait_start(s);
    req_valid = '0;
    while (cyc < s + 32) @(negedge clk);
    check("wd_busy_last_cycle", 32'(busy), 32'd1);
    check("wd_err_not_yet", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("wd_idle", 32'(busy), 32'd0);
    check("wd_err_set", 32'(timeout_err), 32'd1);
    check("wd_no_sent", 32'(req_sent), 32'd0);
    tx_done = 1'b1;
    stuck   = 1'b0;
    frame_delay = 4;
    repeat (3) @(negedge clk);
    check("wd_err_sticky", 32'(timeout_err), 32'd1);
    req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
    push_frame(2'd2, 8'h5A, 1'b1);
    req_valid = 4'b0100;
    wait_start(s);
    req_valid = '0;
    drain();
    check("wd_err_still_set", 32'(timeout_err), 32'd1);

    // Reset mid-BUSY
    frame_delay = 25;
    req_data = {8'h00, 8'h77, 8'h00, 8'h00};
    push_frame(2'd2, 8'h77, 1'b0);
    req_valid = 4'b0100;
    wait_start(s);
    req_valid = '0;
    repeat (3) @(negedge clk);
    kill  = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_tx_din", 32'(tx_din), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd0);
    check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    check("mid_rst_req_sent", 32'(req_sent), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    reset   = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    kill        = 1'b0;
    frame_delay = 6;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    push_frame(2'd0, 8'h11, 1'b1);
    req_valid = 4'b1111;
    wait_start(s);
    req_valid = '0;
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
